// File: rtl/message_display_driver.sv
// rtl/message_display_driver.sv - four-digit multiplexed seven-segment message scroller
//
// Purpose:
//   Shows four consecutive characters from a 16-entry character store on a
//   multiplexed four-digit seven-segment display. The window starts at a base
//   index. The base is latched from scroll_addr once per frame, at the start of
//   digit 0. Each digit slot begins with an anode-off dead time (BLANK) and then
//   shows its character (SHOW).
//
// Configuration:
//   CHAR_RAM_WRITE_EN - when defined, the write ports exist and the store is a
//                       writable RAM. When undefined, the store is a constant
//                       ROM with entry i = i.
//
// Parameters:
//   SLOT_CYCLES  - clock cycles per digit slot
//   BLANK_CYCLES - anode-off cycles at the start of each slot (1..SLOT_CYCLES-1)
//
// Ports:
//   clk         in   1  clock, rising edge
//   reset       in   1  synchronous reset, active low
//   scroll_addr in   4  message start index, latched once per frame
//   wr_en       in   1  character write strobe         (CHAR_RAM_WRITE_EN)
//   wr_addr     in   4  character write index          (CHAR_RAM_WRITE_EN)
//   wr_data     in   4  character code                 (CHAR_RAM_WRITE_EN)
//   an_n        out  4  digit anodes, active low, digit d on an_n[3-d]
//   seg_n       out  7  segments {a,b,c,d,e,f,g}, active low
//   frame_start out  1  one-cycle pulse after the base index is latched

module message_display_driver #(
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] scroll_addr,
`ifdef CHAR_RAM_WRITE_EN
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [3:0] wr_data,
`endif
   output logic [3:0] an_n,
   output logic [6:0] seg_n,
   output logic       frame_start
);

   localparam int            CW        = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(SLOT_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYCLES);

   typedef enum logic {ST_BLANK, ST_SHOW} state_t;

   state_t        state;
   logic [CW-1:0] slot_cnt;
   logic [CW-1:0] nxt_cnt;
   logic [1:0]    digit;
   logic [1:0]    nxt_digit;
   logic [3:0]    base;
   logic [3:0]    rd_base;
   logic [3:0]    rd_idx;
   logic [3:0]    rd_char;

   function automatic logic [6:0] decode(input logic [3:0] c);
      case (c)
         4'h0: decode = 7'h01;
         4'h1: decode = 7'h4F;
         4'h2: decode = 7'h12;
         4'h3: decode = 7'h06;
         4'h4: decode = 7'h4C;
         4'h5: decode = 7'h24;
         4'h6: decode = 7'h20;
         4'h7: decode = 7'h0F;
         4'h8: decode = 7'h00;
         4'h9: decode = 7'h04;
         4'hA: decode = 7'h08;
         4'hB: decode = 7'h60;
         4'hC: decode = 7'h31;
         4'hD: decode = 7'h42;
         4'hE: decode = 7'h30;
         default: decode = 7'h38;
      endcase
   endfunction

   // Outputs are registered from the next-cycle counter values so that an_n
   // and seg_n line up with slot_cnt/digit as they appear after the edge.
   always_comb begin
      nxt_cnt   = (slot_cnt == LAST_CNT) ? '0 : slot_cnt + 1'b1;
      nxt_digit = (slot_cnt == LAST_CNT) ? digit + 2'd1 : digit;
      // When BLANK_CYCLES is 1, the first character fetch coincides with the
      // base latch edge, so bypass the incoming scroll_addr.
      rd_base   = ((slot_cnt == '0) && (digit == 2'd0)) ? scroll_addr : base;
      rd_idx    = rd_base + {2'b00, nxt_digit};
   end

`ifdef CHAR_RAM_WRITE_EN
   logic [3:0] char_store [16];

   // A read of the index being written returns the old entry, because the
   // fetch registers seg_n on the same edge as the write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            char_store[i] <= 4'(i);
         end
      end else if (wr_en) begin
         char_store[wr_addr] <= wr_data;
      end
   end

   assign rd_char = char_store[rd_idx];
`else
   // The constant store holds entry i = i, so the index is the character.
   assign rd_char = rd_idx;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_BLANK;
         slot_cnt    <= '0;
         digit       <= 2'd0;
         base        <= 4'd0;
         an_n        <= 4'b1111;
         seg_n       <= 7'h7F;
         frame_start <= 1'b0;
      end else begin
         slot_cnt    <= nxt_cnt;
         digit       <= nxt_digit;
         frame_start <= (slot_cnt == '0) && (digit == 2'd0);

         if ((slot_cnt == '0) && (digit == 2'd0)) begin
            base <= scroll_addr;
         end

         if (nxt_cnt < BLANK_CNT) begin
            state <= ST_BLANK;
            an_n  <= 4'b1111;
         end else begin
            state <= ST_SHOW;
            an_n  <= ~(4'b1000 >> nxt_digit);
         end

         // seg_n changes only on entry to SHOW and holds through BLANK.
         if ((state == ST_BLANK) && (nxt_cnt >= BLANK_CNT)) begin
            seg_n <= decode(rd_char);
         end
      end
   end

endmodule

// File: tb/tb_message_display_driver.sv
// tb/tb_message_display_driver.sv - directed self-checking bench for message_display_driver

module tb_message_display_driver;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] scroll_addr = 4'd0;
`ifdef CHAR_RAM_WRITE_EN
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = 4'd0;
   logic [3:0] wr_data = 4'd0;
`endif
   logic [3:0] an_n;
   logic [6:0] seg_n;
   logic       frame_start;

   int checks = 0;
   int failures = 0;

   logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   message_display_driver #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .scroll_addr (scroll_addr),
`ifdef CHAR_RAM_WRITE_EN
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
`endif
      .an_n        (an_n),
      .seg_n       (seg_n),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // k counts rising edges since reset release; edge k leaves slot_cnt = k%8.
   function automatic logic [3:0] exp_an(input int k);
      if ((k % 8) < 2) return 4'b1111;
      return ~(4'b1000 >> ((k / 8) % 4));
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (an_n !== 4'b1111) begin failures++; $display("FAIL reset_an cyc=%0d got=%b exp=1111", i, an_n); end
         checks++;
         if (seg_n !== 7'h7F) begin failures++; $display("FAIL reset_seg cyc=%0d got=%h exp=7f", i, seg_n); end
         checks++;
         if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_fs cyc=%0d got=%b exp=0", i, frame_start); end
      end
   endtask

   task automatic test_scroll0();
      logic [6:0] es;
      int d;
      reset = 1'b0; scroll_addr = 4'd0;
      @(negedge clk);
      reset = 1'b1; es = 7'h7F;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         d = (k / 8) % 4;
         if ((k % 8) == 2) es = seg_tab[4'(d)];
         checks++;
         if (an_n !== exp_an(k)) begin failures++; $display("FAIL scroll0_an k=%0d got=%b exp=%b", k, an_n, exp_an(k)); end
         checks++;
         if (seg_n !== es) begin failures++; $display("FAIL scroll0_seg k=%0d got=%h exp=%h", k, seg_n, es); end
         checks++;
         if (frame_start !== ((k % 32) == 1)) begin failures++; $display("FAIL scroll0_fs k=%0d got=%b exp=%b", k, frame_start, (k % 32) == 1); end
      end
   endtask

   task automatic test_wrap14();
      logic [6:0] es;
      logic [6:0] exp_digit [4];
      int d;
      exp_digit = '{7'h30, 7'h38, 7'h01, 7'h4F};
      reset = 1'b0; scroll_addr = 4'd14;
      @(negedge clk);
      reset = 1'b1; es = 7'h7F;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         d = (k / 8) % 4;
         if ((k % 8) == 2) es = exp_digit[d];
         checks++;
         if (an_n !== exp_an(k)) begin failures++; $display("FAIL wrap14_an k=%0d got=%b exp=%b", k, an_n, exp_an(k)); end
         checks++;
         if (seg_n !== es) begin failures++; $display("FAIL wrap14_seg k=%0d got=%h exp=%h", k, seg_n, es); end
      end
   endtask

   task automatic test_scroll_change();
      logic [6:0] es;
      logic [6:0] exp_seq [8];
      exp_seq = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h24, 7'h20, 7'h0F, 7'h00};
      reset = 1'b0; scroll_addr = 4'd0;
      @(negedge clk);
      reset = 1'b1; es = 7'h7F;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if ((k % 8) == 2) es = exp_seq[k / 8];
         checks++;
         if (seg_n !== es) begin failures++; $display("FAIL scroll_change_seg k=%0d got=%h exp=%h", k, seg_n, es); end
         checks++;
         if (frame_start !== ((k % 32) == 1)) begin failures++; $display("FAIL scroll_change_fs k=%0d got=%b exp=%b", k, frame_start, (k % 32) == 1); end
         if (k == 12) scroll_addr = 4'd5;
      end
   endtask

   task automatic test_reset_mid_show();
      reset = 1'b0; scroll_addr = 4'd0;
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (an_n !== 4'b1101) begin failures++; $display("FAIL midrst_pre_an got=%b exp=1101", an_n); end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (an_n !== 4'b1111) begin failures++; $display("FAIL midrst_an got=%b exp=1111", an_n); end
      checks++;
      if (seg_n !== 7'h7F) begin failures++; $display("FAIL midrst_seg got=%h exp=7f", seg_n); end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (frame_start !== 1'b1) begin failures++; $display("FAIL midrst_fs got=%b exp=1", frame_start); end
      checks++;
      if (an_n !== 4'b1111) begin failures++; $display("FAIL midrst_blank_an got=%b exp=1111", an_n); end
      @(negedge clk);
      checks++;
      if (an_n !== 4'b0111) begin failures++; $display("FAIL midrst_d0_an got=%b exp=0111", an_n); end
      checks++;
      if (seg_n !== 7'h01) begin failures++; $display("FAIL midrst_d0_seg got=%h exp=01", seg_n); end
      checks++;
      if (frame_start !== 1'b0) begin failures++; $display("FAIL midrst_fs_low got=%b exp=0", frame_start); end
   endtask

`ifdef CHAR_RAM_WRITE_EN
   task automatic test_write();
      reset = 1'b0; scroll_addr = 4'd0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);                          // k=1, digit 0
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'hA;
      @(negedge clk);                          // k=2
      wr_en = 1'b0;
      repeat (16) @(negedge clk);              // k=18, digit 2 SHOW
      checks++;
      if (seg_n !== 7'h08) begin failures++; $display("FAIL write_d2_seg got=%h exp=08", seg_n); end
      repeat (7) @(negedge clk);               // k=25
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 4'hF;
      @(negedge clk);                          // k=26, fetch and write of index 3 on same edge
      wr_en = 1'b0;
      checks++;
      if (seg_n !== 7'h06) begin failures++; $display("FAIL write_same_cycle got=%h exp=06", seg_n); end
      repeat (32) @(negedge clk);              // k=58, digit 3 of next frame
      checks++;
      if (seg_n !== 7'h38) begin failures++; $display("FAIL write_d3_next got=%h exp=38", seg_n); end
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (18) @(negedge clk);              // store restored by reset
      checks++;
      if (seg_n !== 7'h12) begin failures++; $display("FAIL write_reset_restore got=%h exp=12", seg_n); end
   endtask
`endif

   initial begin
      test_reset();
      test_scroll0();
      test_wrap14();
      test_scroll_change();
      test_reset_mid_show();
`ifdef CHAR_RAM_WRITE_EN
      test_write();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
